rvc_asap_core: RTL and testbench



---
 rtl/rvc_asap_core.sv | 149 ++++++++++++++
 tb/tb_rvc_asap_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_asap_core.sv
// rvc_asap_core: single-cycle RV32I core with internal byte-addressed IMem/DMem
// Ports: Clock - core clock, all state updates on rising edge
//        Rst   - synchronous active-high reset (PC and x1..x31 cleared, memories kept)
// Optional: define RVC_ASAP_HALT_EN to make ECALL/EBREAK halt the core until reset
module rvc_asap_core #(
    parameter int I_MEM_MSB = 1023,
    parameter int D_MEM_MSB = 2047
) (
    input logic Clock,
    input logic Rst
);
    localparam int IW = $clog2(I_MEM_MSB + 1);
    localparam int DW = $clog2(D_MEM_MSB + 1);
    localparam logic [31:0] I_HI = I_MEM_MSB;
    localparam logic [31:0] D_LO = I_MEM_MSB + 1;
    localparam logic [31:0] D_HI = D_MEM_MSB;
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

    logic [7:0] IMem [I_MEM_MSB:0];
    logic [7:0] DMem [D_MEM_MSB:I_MEM_MSB+1];

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] instr, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_v, rs2_v, alu_b, alu_y, addr, ld_v, rd_v;
    logic [31:0] ba [4];
    logic [7:0]  lb [4];
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [3:0]  st_mask, b_ok;
    logic        rd_we, take;

    function automatic logic [7:0] ifetch(input logic [31:0] a);
        return (a <= I_HI) ? IMem[a[IW-1:0]] : 8'h00;
    endfunction

    assign instr = {ifetch(pc_q + 32'd3), ifetch(pc_q + 32'd2), ifetch(pc_q + 32'd1), ifetch(pc_q)};
    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign alu_b = (opc == OP_REG) ? rs2_v : imm_i;
    assign addr  = rs1_v + ((opc == OP_ST) ? imm_s : imm_i);

    // instr[30] selects SUB (register form only) and SRA/SRAI
    always_comb begin
        case (f3)
            3'd0:    alu_y = (opc == OP_REG && instr[30]) ? rs1_v - alu_b : rs1_v + alu_b;
            3'd1:    alu_y = rs1_v << alu_b[4:0];
            3'd2:    alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
            3'd3:    alu_y = {31'd0, rs1_v < alu_b};
            3'd4:    alu_y = rs1_v ^ alu_b;
            3'd5:    alu_y = instr[30] ? $unsigned($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
            3'd6:    alu_y = rs1_v | alu_b;
            default: alu_y = rs1_v & alu_b;
        endcase
    end

    always_comb begin
        case (f3)
            3'd0:    take = rs1_v == rs2_v;
            3'd1:    take = rs1_v != rs2_v;
            3'd4:    take = $signed(rs1_v) < $signed(rs2_v);
            3'd5:    take = $signed(rs1_v) >= $signed(rs2_v);
            3'd6:    take = rs1_v < rs2_v;
            3'd7:    take = rs1_v >= rs2_v;
            default: take = 1'b0;
        endcase
    end

    // per-byte data addresses; bytes outside DMem read 0 and are never written
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ba[k]   = addr + 32'(k);
            b_ok[k] = ba[k] >= D_LO && ba[k] <= D_HI;
            lb[k]   = b_ok[k] ? DMem[ba[k][DW-1:0]] : 8'h00;
        end
    end

    always_comb begin
        case (f3)
            3'd0:    ld_v = {{24{lb[0][7]}}, lb[0]};
            3'd1:    ld_v = {{16{lb[1][7]}}, lb[1], lb[0]};
            3'd2:    ld_v = {lb[3], lb[2], lb[1], lb[0]};
            3'd4:    ld_v = {24'd0, lb[0]};
            3'd5:    ld_v = {16'd0, lb[1], lb[0]};
            default: ld_v = 32'd0;
        endcase
    end

`ifdef RVC_ASAP_HALT_EN
    logic halted_q, halted_d;
`endif

    always_comb begin
        pc_d    = pc_q + 32'd4;
        rd_we   = 1'b0;
        rd_v    = alu_y;
        st_mask = 4'b0000;
        case (opc)
            OP_LUI:   begin rd_we = 1'b1; rd_v = imm_u; end
            OP_AUIPC: begin rd_we = 1'b1; rd_v = pc_q + imm_u; end
            OP_JAL:   begin rd_we = 1'b1; rd_v = pc_q + 32'd4; pc_d = pc_q + imm_j; end
            OP_JALR:  if (f3 == 3'd0) begin rd_we = 1'b1; rd_v = pc_q + 32'd4; pc_d = (rs1_v + imm_i) & ~32'd1; end
            OP_BR:    if (take) pc_d = pc_q + imm_b;
            OP_LD:    begin rd_we = f3 != 3'd3 && f3 < 3'd6; rd_v = ld_v; end
            OP_ST:    st_mask = (f3 == 3'd0) ? 4'b0001 : (f3 == 3'd1) ? 4'b0011 : (f3 == 3'd2) ? 4'b1111 : 4'b0000;
            OP_IMM:   rd_we = 1'b1;
            OP_REG:   rd_we = 1'b1;
            default:  ;
        endcase
`ifdef RVC_ASAP_HALT_EN
        // ECALL/EBREAK freeze the core on their own PC until reset
        halted_d = halted_q | (instr == 32'h0000_0073) | (instr == 32'h0010_0073);
        if (halted_d) begin
            pc_d    = pc_q;
            rd_we   = 1'b0;
            st_mask = 4'b0000;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            pc_q <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (rd_we && rd != 5'd0) rf_q[rd] <= rd_v;
            for (int k = 0; k < 4; k++)
                if (st_mask[k] && b_ok[k]) DMem[ba[k][DW-1:0]] <= rs2_v[8*k +: 8];
        end
    end

`ifdef RVC_ASAP_HALT_EN
    always_ff @(posedge Clock) halted_q <= Rst ? 1'b0 : halted_d;
`endif

endmodule

// File: tb/tb_rvc_asap_core.sv
// tb_rvc_asap_core: scoreboard bench for rvc_asap_core; programs are poked into IMem during reset
module tb_rvc_asap_core;
    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, JALR = 7'h67;
    localparam logic [6:0] OPI = 7'h13, LD = 7'h03;

    logic Clock = 1'b0;
    logic Rst = 1'b1;
    int total = 0;
    int bad = 0;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    rvc_asap_core dut (.Clock(Clock), .Rst(Rst));

    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ei(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] es(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] eb(input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] eu(input logic [31:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm[31:12], rd, op};
    endfunction
    function automatic logic [31:0] ej(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    function automatic logic [31:0] obs(input int kind, input int idx);
        if (kind == 0) return dut.pc_q;
        if (kind == 1) return dut.rf_q[idx];
        return {dut.DMem[idx+3], dut.DMem[idx+2], dut.DMem[idx+1], dut.DMem[idx]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic want(input string tag, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.kind = kind;
        e.idx = idx;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs(e.kind, e.idx), e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic start();
        Rst = 1'b1;
        for (int a = 0; a < 1024; a++) dut.IMem[a] = 8'h00;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) dut.IMem[a+k] = w[8*k +: 8];
    endtask

    task automatic go();
        step(4);
        want("rst_pc", 0, 0, 32'd0);
        want("rst_x1", 1, 1, 32'd0);
        drain();
        Rst = 1'b0;
    endtask

    initial begin
        // reset and fetch
        start();
        put(0, ei(5, 0, 0, 1, OPI));
        put(4, ei(-3, 1, 0, 2, OPI));
        go();
        step(2);
        want("t1_pc", 0, 0, 32'h8);
        want("t1_x1", 1, 1, 32'd5);
        want("t1_x2", 1, 2, 32'd2);
        drain();

        // ALU and shifts
        start();
        put(32'h00, eu(32'h8000_0000, 1, LUI));
        put(32'h04, ei(32'h404, 1, 5, 3, OPI));
        put(32'h08, ei(4, 1, 5, 4, OPI));
        put(32'h0c, er(7'h20, 1, 0, 0, 5));
        put(32'h10, er(7'h00, 1, 0, 3, 6));
        put(32'h14, er(7'h00, 0, 1, 2, 7));
        put(32'h18, ei(-1, 1, 4, 8, OPI));
        put(32'h1c, er(7'h00, 1, 1, 0, 9));
        put(32'h20, eu(32'h0000_1000, 10, AUIPC));
        go();
        step(9);
        want("srai", 1, 3, 32'hF800_0000);
        want("srli", 1, 4, 32'h0800_0000);
        want("sub", 1, 5, 32'h8000_0000);
        want("sltu", 1, 6, 32'd1);
        want("slt", 1, 7, 32'd1);
        want("xori", 1, 8, 32'h7FFF_FFFF);
        want("add_wrap", 1, 9, 32'd0);
        want("auipc", 1, 10, 32'h0000_1020);
        want("t2_pc", 0, 0, 32'h24);
        drain();

        // loads and stores
        start();
        put(32'h00, eu(32'h1122_3000, 2, LUI));
        put(32'h04, ei(32'h344, 2, 0, 2, OPI));
        put(32'h08, ei(32'h400, 0, 0, 3, OPI));
        put(32'h0c, es(0, 3, 2, 2));
        put(32'h10, ei(3, 3, 0, 4, LD));
        put(32'h14, ei(2, 3, 1, 5, LD));
        put(32'h18, ei(-1, 0, 0, 6, OPI));
        put(32'h1c, es(1, 3, 6, 0));
        put(32'h20, ei(1, 3, 4, 7, LD));
        put(32'h24, ei(1, 3, 0, 8, LD));
        put(32'h28, ei(0, 3, 2, 9, LD));
        put(32'h2c, es(32'h3FE, 3, 2, 2));
        put(32'h30, ei(32'h3FE, 3, 2, 10, LD));
        go();
        step(13);
        want("lb", 1, 4, 32'h0000_0011);
        want("lh", 1, 5, 32'h0000_1122);
        want("lbu", 1, 7, 32'h0000_00FF);
        want("lb_neg", 1, 8, 32'hFFFF_FFFF);
        want("lw", 1, 9, 32'h1122_FF44);
        want("lw_edge", 1, 10, 32'h0000_3344);
        want("dmem400", 2, 32'h400, 32'h1122_FF44);
        want("t3_pc", 0, 0, 32'h34);
        drain();

        // control flow
        start();
        put(32'h00, ei(3, 0, 0, 5, OPI));
        put(32'h04, ei(3, 0, 0, 6, OPI));
        put(32'h10, eb(8, 5, 6, 0));
        put(32'h14, ei(99, 0, 0, 7, OPI));
        put(32'h18, eb(100, 5, 6, 1));
        put(32'h1c, eb(12, 1, 0, 1));
        put(32'h20, ej(-16, 1));
        put(32'h24, ei(1, 0, 0, 8, OPI));
        put(32'h28, ei(1, 1, 0, 0, JALR));
        go();
        step(5);
        want("beq_taken", 0, 0, 32'h18);
        drain();
        step(1);
        want("bne_not", 0, 0, 32'h1c);
        drain();
        step(2);
        want("jal_pc", 0, 0, 32'h10);
        want("jal_link", 1, 1, 32'h24);
        drain();
        step(4);
        want("jalr_pc", 0, 0, 32'h24);
        want("jalr_x0", 1, 0, 32'd0);
        drain();
        step(1);
        want("t4_x8", 1, 8, 32'd1);
        want("t4_skip", 1, 7, 32'd0);
        want("t4_pc", 0, 0, 32'h28);
        drain();

        // signed vs unsigned branches
        start();
        put(32'h00, ei(-1, 0, 0, 1, OPI));
        put(32'h04, ei(1, 0, 0, 2, OPI));
        put(32'h08, eb(8, 1, 2, 6));
        put(32'h0c, eb(8, 1, 2, 4));
        put(32'h10, ei(9, 0, 0, 3, OPI));
        put(32'h14, eb(8, 1, 2, 7));
        put(32'h18, ei(9, 0, 0, 3, OPI));
        put(32'h1c, eb(8, 1, 2, 5));
        go();
        step(6);
        want("t5_pc", 0, 0, 32'h20);
        want("t5_x3", 1, 3, 32'd0);
        drain();

        // x0 and NOP-like words
        start();
        put(32'h00, ei(7, 0, 0, 0, OPI));
        put(32'h08, 32'h0000_0073);
        put(32'h0c, ei(1, 0, 0, 1, OPI));
        go();
        step(4);
        want("x0", 1, 0, 32'd0);
`ifdef RVC_ASAP_HALT_EN
        want("ecall_pc", 0, 0, 32'h8);
        want("ecall_x1", 1, 1, 32'd0);
`else
        want("nop_pc", 0, 0, 32'h10);
        want("nop_x1", 1, 1, 32'd1);
`endif
        drain();

        // reset in the middle of a running loop
        start();
        put(32'h00, ei(1, 1, 0, 1, OPI));
        put(32'h04, ej(-4, 0));
        go();
        step(4);
        want("loop_x1", 1, 1, 32'd2);
        drain();
        Rst = 1'b1;
        step(1);
        want("mid_rst_pc", 0, 0, 32'd0);
        want("mid_rst_x1", 1, 1, 32'd0);
        drain();
        Rst = 1'b0;
        step(1);
        want("resume_x1", 1, 1, 32'd1);
        want("resume_pc", 0, 0, 32'h4);
        drain();

`ifdef RVC_ASAP_HALT_EN
        start();
        put(32'h00, ei(1, 0, 0, 1, OPI));
        put(32'h04, ei(2, 0, 0, 2, OPI));
        put(32'h08, ei(8, 0, 0, 4, OPI));
        put(32'h0c, 32'h0010_0073);
        put(32'h10, ei(3, 0, 0, 3, OPI));
        go();
        step(104);
        want("halt_pc", 0, 0, 32'h0c);
        want("halt_x3", 1, 3, 32'd0);
        want("halt_x4", 1, 4, 32'd8);
        drain();
        Rst = 1'b1;
        step(1);
        want("halt_rst_pc", 0, 0, 32'd0);
        drain();
        Rst = 1'b0;
        step(2);
        want("halt_resume_pc", 0, 0, 32'h8);
        want("halt_resume_x2", 1, 2, 32'd2);
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
